// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet arbiter/mux: word layout, header codes and arbiter states.
package pkt_arb_pkg;

    localparam int PKT_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic {IDLE, SEND} arb_state_t;

    function automatic logic hdr_is(input logic [PKT_W-1:0] word, input logic [1:0] code);
        return word[PKT_W-1 -: 2] == code;
    endfunction

endpackage

// File: rtl/pkt_adm_fifo.sv
// Store-and-forward input FIFO with per-packet admission at the head word,
// completed-packet counter, almost-full flag and saturating drop counter.
module pkt_adm_fifo
    import pkt_arb_pkg::*;
#(
    parameter int FIFO_DEPTH    = 256,
    parameter int PKT_MAX_WORDS = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [PKT_W-1:0] data,
    input  logic             valid_wr,
    input  logic             valid,
    output logic             alf,
    input  logic             rd_en,
    output logic [PKT_W:0]   rd_data,
    output logic             rd_tail,
    output logic             pkt_avail,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ALF_TH = (AW+1)'(FIFO_DEPTH - PKT_MAX_WORDS);
    localparam logic [AW:0] INC    = {{AW{1'b0}}, 1'b1};

    logic [PKT_W:0] mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr, occ, pkt_cnt;
    logic           discard, is_head, is_tail, full, empty, we, re, head_is_tail;

    assign occ     = wr_ptr - rd_ptr;
    assign full    = occ[AW];
    assign empty   = (occ == '0);
    assign alf     = (occ > ALF_TH);
    assign is_head = hdr_is(data, HDR_HEAD);
    assign is_tail = hdr_is(data, HDR_TAIL);

    // The head decides for the whole packet; discard stays set outside packets.
    assign we = wr && !full && (is_head ? !alf : !discard);
    assign re = rd_en && !empty;

    assign head_is_tail = hdr_is(mem[rd_ptr[AW-1:0]][PKT_W-1:0], HDR_TAIL);
    assign rd_tail      = head_is_tail && !empty;
    assign pkt_avail    = (pkt_cnt != '0);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr[AW-1:0]] <= {is_tail & valid_wr & valid, data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            rd_data  <= '0;
            discard  <= 1'b1;
            drop_cnt <= '0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + INC;
            end
            if (re) begin
                rd_ptr  <= rd_ptr + INC;
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
            if (wr && is_head) begin
                discard <= alf;
                if (alf && drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (wr && is_tail) begin
                discard <= 1'b1;
            end
            case ({we && is_tail, re && head_is_tail})
                2'b10:   pkt_cnt <= pkt_cnt + INC;
                2'b01:   pkt_cnt <= pkt_cnt - INC;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: rtl/pkt_arb_mux.sv
// Two-input packet arbiter/mux onto one egress stream; round-robin by default,
// strict priority for input 1 (PTP) when PKT_ARB_PTP_PRIO_EN is defined.
module pkt_arb_mux
    import pkt_arb_pkg::*;
#(
    parameter int FIFO_DEPTH    = 256,
    parameter int PKT_MAX_WORDS = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_data_wr,
    input  logic [PKT_W-1:0] in0_data,
    input  logic             in0_data_valid_wr,
    input  logic             in0_data_valid,
    output logic             in0_data_alf,
    input  logic             in1_data_wr,
    input  logic [PKT_W-1:0] in1_data,
    input  logic             in1_data_valid_wr,
    input  logic             in1_data_valid,
    output logic             in1_data_alf,
    output logic             out_data_wr,
    output logic [PKT_W-1:0] out_data,
    output logic             out_data_valid_wr,
    output logic             out_data_valid,
    input  logic             out_data_alf,
    output logic [7:0]       drop_cnt0,
    output logic [7:0]       drop_cnt1
);

    logic [PKT_W:0] rd_data0, rd_data1, rd_word;
    logic           rd_en0, rd_en1, rd_tail0, rd_tail1, avail0, avail1;
    logic           req0, req1, gnt, gnt_any, cur_tail;
    logic           sel, last, cool, rd_fire_q, rd_sel_q;
    arb_state_t     state;

    pkt_adm_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PKT_MAX_WORDS(PKT_MAX_WORDS)) u_fifo0 (
        .clk(clk), .rst_n(rst_n), .wr(in0_data_wr), .data(in0_data),
        .valid_wr(in0_data_valid_wr), .valid(in0_data_valid), .alf(in0_data_alf),
        .rd_en(rd_en0), .rd_data(rd_data0), .rd_tail(rd_tail0),
        .pkt_avail(avail0), .drop_cnt(drop_cnt0)
    );

    pkt_adm_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PKT_MAX_WORDS(PKT_MAX_WORDS)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .wr(in1_data_wr), .data(in1_data),
        .valid_wr(in1_data_valid_wr), .valid(in1_data_valid), .alf(in1_data_alf),
        .rd_en(rd_en1), .rd_data(rd_data1), .rd_tail(rd_tail1),
        .pkt_avail(avail1), .drop_cnt(drop_cnt1)
    );

    assign req0 = avail0 && !out_data_alf;
    assign req1 = avail1 && !out_data_alf;

`ifdef PKT_ARB_PTP_PRIO_EN
    assign gnt = req1;
`else
    assign gnt = (req0 && req1) ? ~last : req1;
`endif

    // The head is read in the granting IDLE cycle so it reaches egress at T+3;
    // cool holds IDLE one cycle after a tail to leave a gap between packets.
    assign gnt_any  = (state == IDLE) && !cool && (req0 || req1);
    assign rd_en0   = (state == SEND) ? !sel : (gnt_any && !gnt);
    assign rd_en1   = (state == SEND) ?  sel : (gnt_any &&  gnt);
    assign cur_tail = sel ? rd_tail1 : rd_tail0;
    assign rd_word  = rd_sel_q ? rd_data1 : rd_data0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            sel               <= 1'b0;
            last              <= 1'b1;
            cool              <= 1'b0;
            rd_fire_q         <= 1'b0;
            rd_sel_q          <= 1'b0;
            out_data_wr       <= 1'b0;
            out_data          <= '0;
            out_data_valid_wr <= 1'b0;
            out_data_valid    <= 1'b0;
        end else begin
            rd_fire_q         <= rd_en0 || rd_en1;
            rd_sel_q          <= rd_en1;
            out_data_wr       <= rd_fire_q;
            out_data          <= rd_fire_q ? rd_word[PKT_W-1:0] : '0;
            out_data_valid_wr <= rd_fire_q && hdr_is(rd_word[PKT_W-1:0], HDR_TAIL);
            out_data_valid    <= rd_fire_q && hdr_is(rd_word[PKT_W-1:0], HDR_TAIL) && rd_word[PKT_W];
            case (state)
                IDLE: begin
                    cool <= 1'b0;
                    if (gnt_any) begin
                        state <= SEND;
                        sel   <= gnt;
                        last  <= gnt;
                    end
                end
                SEND: begin
                    if (cur_tail) begin
                        state <= IDLE;
                        cool  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_arb_mux.sv
// Self-checking bench for pkt_arb_mux: packet-level reference model with admission and arbitration.
module tb_pkt_arb_mux;
    import pkt_arb_pkg::*;

    localparam int DEPTH = 256;
    localparam int PMAX  = 128;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in0_data_wr = 0, in0_data_valid_wr = 0, in0_data_valid = 0, in0_data_alf;
    logic         in1_data_wr = 0, in1_data_valid_wr = 0, in1_data_valid = 0, in1_data_alf;
    logic [133:0] in0_data = '0, in1_data = '0, out_data;
    logic         out_data_wr, out_data_valid_wr, out_data_valid, out_data_alf = 1'b0;
    logic [7:0]   drop_cnt0, drop_cnt1;

    pkt_arb_mux #(.FIFO_DEPTH(DEPTH), .PKT_MAX_WORDS(PMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_data_wr(in0_data_wr), .in0_data(in0_data), .in0_data_valid_wr(in0_data_valid_wr),
        .in0_data_valid(in0_data_valid), .in0_data_alf(in0_data_alf),
        .in1_data_wr(in1_data_wr), .in1_data(in1_data), .in1_data_valid_wr(in1_data_valid_wr),
        .in1_data_valid(in1_data_valid), .in1_data_alf(in1_data_alf),
        .out_data_wr(out_data_wr), .out_data(out_data), .out_data_valid_wr(out_data_valid_wr),
        .out_data_valid(out_data_valid), .out_data_alf(out_data_alf),
        .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [133:0] d; logic vwr; logic v; int c; } rx_t;
    typedef struct { logic [133:0] d; logic tail; logic v; logic first; } ex_t;

    rx_t          rxq[$];
    ex_t          exq[$];
    logic [134:0] pw0[$], pw1[$];
    int           pl0[$], pl1[$];
    int           occ[2];
    int           drops[2];
    bit           m_last = 1'b1;
    int           n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_data_wr) rxq.push_back('{out_data, out_data_valid_wr, out_data_valid, cyc});
        else chk("idle_strobes", 32'({out_data_valid_wr, out_data_valid}), 0);
    end

    function automatic logic [131:0] rnd132();
        return {$urandom(), $urandom(), $urandom(), $urandom(), 4'($urandom())};
    endfunction

    function automatic logic alf_of(input int p);
        return (p == 0) ? in0_data_alf : in1_data_alf;
    endfunction

    task automatic drive(input int p, input logic w, input logic [133:0] d, input logic vw, input logic v);
        if (p == 0) begin
            in0_data_wr = w; in0_data = d; in0_data_valid_wr = vw; in0_data_valid = v;
        end else begin
            in1_data_wr = w; in1_data = d; in1_data_valid_wr = vw; in1_data_valid = v;
        end
    endtask

    function automatic logic [1:0] code_of(input int i, input int len);
        return (i == 0) ? HDR_HEAD : ((i == len - 1) ? HDR_TAIL : HDR_BODY);
    endfunction

    // Sends one packet back-to-back; the model admits it when free space >= PMAX.
    task automatic send_pkt(input int p, input int len, input bit good, output int tcyc);
        bit           acc = 1'b0;
        logic         m_alf;
        logic [133:0] d;
        tcyc = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            d = {code_of(i, len), rnd132()};
            if (i == 0) begin
                m_alf = (DEPTH - occ[p]) < PMAX;
                chk((p == 0) ? "alf0_at_head" : "alf1_at_head", 32'(alf_of(p)), 32'(m_alf));
                acc = !m_alf;
                if (!acc && drops[p] < 255) drops[p]++;
            end
            drive(p, 1'b1, d, i == len - 1, good && (i == len - 1));
            if (i == len - 1) tcyc = cyc;
            if (acc) begin
                if (p == 0) pw0.push_back({good && (i == len - 1), d});
                else        pw1.push_back({good && (i == len - 1), d});
            end
        end
        if (acc) begin
            if (p == 0) pl0.push_back(len); else pl1.push_back(len);
            occ[p] += len;
        end
        @(posedge clk); #1;
        drive(p, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Orders all pending packets by the arbitration rule into the expected egress list.
    task automatic plan_all();
        bit           g;
        int           n;
        logic [134:0] w;
        while (pl0.size() != 0 || pl1.size() != 0) begin
`ifdef PKT_ARB_PTP_PRIO_EN
            g = (pl1.size() != 0);
`else
            if (pl0.size() != 0 && pl1.size() != 0) g = !m_last;
            else g = (pl1.size() != 0);
`endif
            m_last = g;
            n = g ? pl1.pop_front() : pl0.pop_front();
            occ[g] -= n;
            for (int i = 0; i < n; i++) begin
                w = g ? pw1.pop_front() : pw0.pop_front();
                exq.push_back('{w[133:0], i == n - 1, w[134], i == 0});
            end
        end
    endtask

    task automatic set_alf(input logic v);
        @(posedge clk); #1;
        out_data_alf = v;
    endtask

    task automatic wait_check(input string tag, input int budget, output int first_c, output int last_c);
        int k = 0, n, prev = 0;
        first_c = 0; last_c = 0;
        while (rxq.size() < exq.size() && k < budget) begin
            @(posedge clk); k++;
        end
        repeat (6) @(posedge clk);
        chk({tag, "_count"}, rxq.size(), exq.size());
        n = (rxq.size() < exq.size()) ? rxq.size() : exq.size();
        for (int i = 0; i < n; i++) begin
            chkw({tag, "_data"}, rxq[i].d, exq[i].d);
            chk({tag, "_strobes"}, 32'({rxq[i].vwr, rxq[i].v}), 32'({exq[i].tail, exq[i].tail & exq[i].v}));
            if (exq[i].first) begin
                if (i == 0) first_c = rxq[i].c;
                else chk({tag, "_gap"}, 32'(rxq[i].c - prev >= 2), 1);
                last_c = rxq[i].c;
            end else begin
                chk({tag, "_contig"}, rxq[i].c, prev + 1);
            end
            prev = rxq[i].c;
        end
        rxq.delete();
        exq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, f, l, rel, k;
        logic [133:0] d;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_out", 32'({out_data_wr, out_data_valid_wr, out_data_valid, |out_data}), 0);
        chk("reset_alf", 32'({in0_data_alf, in1_data_alf}), 0);
        chk("reset_drop", 32'({drop_cnt0, drop_cnt1}), 0);

        // Single packet: head at tail cycle + 3.
        send_pkt(0, 4, 1'b1, t);
        plan_all();
        wait_check("single", 40, f, l);
        chk("single_latency", f, t + 3);

        // Round-robin: deterministic alternating round, then random rounds.
        for (int r = 0; r < 4; r++) begin
            set_alf(1'b1);
            k = (r == 0) ? 4 : int'($urandom_range(3, 6));
            for (int j = 0; j < k; j++) begin
                if (r == 0) send_pkt(j % 2, 3, 1'b1, t);
                else send_pkt(int'($urandom_range(0, 1)), int'($urandom_range(2, 8)), 1'($urandom_range(0, 1)), t);
            end
            plan_all();
            set_alf(1'b0);
            wait_check("rr", 200, f, l);
        end

        // Admission drop at 129 words buffered (free space 127).
        set_alf(1'b1);
        send_pkt(0, 100, 1'b1, t);
        send_pkt(0, 29, 1'b0, t);
        send_pkt(1, 6, 1'b1, t);
        send_pkt(0, 5, 1'b1, t);
        @(posedge clk); #1;
        chk("drop_cnt0", 32'(drop_cnt0), drops[0]);
        chk("drop_cnt1", 32'(drop_cnt1), drops[1]);
        chk("drop_alf0", 32'(in0_data_alf), 1);
        plan_all();
        set_alf(1'b0);
        wait_check("drop", 400, f, l);

        // Backpressure raised mid-packet must not cut it; next packet waits.
        set_alf(1'b1);
        send_pkt(0, 10, 1'b1, t);
        plan_all();
        set_alf(1'b0);
        k = 0;
        while (rxq.size() == 0 && k < 20) begin @(posedge clk); k++; end
        chk("bp_started", 32'(rxq.size() != 0), 1);
        #1 out_data_alf = 1'b1;
        send_pkt(1, 3, 1'b1, t);
        plan_all();
        repeat (20) @(posedge clk);
        chk("bp_hold", rxq.size(), 10);
        set_alf(1'b0);
        rel = cyc;
        wait_check("bp", 60, f, l);
        chk("bp_after_release", 32'(l > rel), 1);

        // Reset mid-packet while an egress packet is also in flight.
        set_alf(1'b1);
        send_pkt(1, 20, 1'b1, t);
        set_alf(1'b0);
        k = 0;
        while (rxq.size() == 0 && k < 20) begin @(posedge clk); k++; end
        chk("rst_egress_started", 32'(rxq.size() != 0), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b0;
            if (i == 2) begin
                chk("rst_out", 32'({out_data_wr, out_data_valid_wr, out_data_valid, |out_data}), 0);
                chk("rst_drop", 32'({drop_cnt0, drop_cnt1}), 0);
                chk("rst_alf", 32'({in0_data_alf, in1_data_alf}), 0);
                rst_n = 1'b1;
                rxq.delete();
                pw0.delete(); pw1.delete(); pl0.delete(); pl1.delete();
                occ[0] = 0; occ[1] = 0; drops[0] = 0; drops[1] = 0;
                m_last = 1'b1;
            end
            d = {code_of(i, 6), rnd132()};
            drive(0, 1'b1, d, i == 5, i == 5);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        chk("rst_no_egress", rxq.size(), 0);

        // After reset input 0 wins the first tie.
        set_alf(1'b1);
        send_pkt(1, 3, 1'b1, t);
        send_pkt(0, 4, 1'b0, t);
        plan_all();
        set_alf(1'b0);
        wait_check("rst_tie", 60, f, l);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_arb_mux.md
# pkt_arb_mux

Two-input, packet-granular arbiter that merges the DMUX forward path (`parser2mux_*`) and the local PTP transmit stream onto the single 134-bit egress stream toward the switching/TX logic. Each input is buffered in its own store-and-forward FIFO. The block forwards only complete packets, one at a time, with no interleaving. Admission is decided per packet at the header, so a FIFO never holds a partial packet.

## Interface
- `FIFO_DEPTH`, 256: words per input FIFO (power of two).
- `PKT_MAX_WORDS`, 128: maximum packet length in words, metadata included; also the admission headroom.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in0_data_wr` in 1: word strobe, DMUX forward path.
- `in0_data` in 134: word; [133:132] = 01 head, 11 body, 10 tail.
- `in0_data_valid_wr` in 1: packet-status strobe, coincident with the tail word.
- `in0_data_valid` in 1: packet good flag.
- `in0_data_alf` out 1: almost full.
- `in1_*`: same five signals, for the local PTP stream.
- `out_data_wr` out 1: egress word strobe.
- `out_data` out 134: egress word.
- `out_data_valid_wr` out 1: egress status strobe.
- `out_data_valid` out 1: egress good flag.
- `out_data_alf` in 1: downstream almost full.
- `drop_cnt0`, `drop_cnt1` out 8: saturating count of packets refused at admission.

## Operation
- **FIFO word format.** Each FIFO word is 135 bits: {valid, data}. The valid bit is captured from `inX_data_valid` on the tail word; it is 0 on all other words.
- **Alf.** `inX_data_alf` = 1 when FIFO free space < `PKT_MAX_WORDS`. It is combinational from the registered occupancy.
- **Admission.** Decided at the head word (`wr`=1, code 01):
  - alf=0: accept; write every word through the tail.
  - alf=1: discard every word through the tail and increment `drop_cntX`, saturating at 255.
- **Out-of-contract input.** A write while the FIFO is full is ignored. Packets longer than `PKT_MAX_WORDS` are out of contract.
- **Completed-packet counter.** `pkt_cntX` increments on each accepted tail write and decrements on each tail read. A simultaneous increment and decrement leaves it unchanged.
- **Arbiter FSM.**
  - IDLE: a request is `pkt_cntX`≠0 and `out_data_alf`=0. Grant per round-robin, then go to SEND.
  - Round-robin: the `last` register holds the last granted input. With both inputs requesting, grant the other input; with one requesting, grant it. `last` updates on grant.
  - SEND: read one word per cycle from the granted FIFO. `out_data_alf` is ignored mid-packet. On reading the tail, go to IDLE.
- **Egress strobes.** `out_data_valid_wr`=1 and `out_data_valid`=the stored valid bit only with the tail word. Otherwise both are 0.
- **Reset.** All outputs 0; both FIFOs empty; counters 0; FSM in IDLE; `last`=1, so input 0 wins the first tie. Reset mid-packet discards all buffered and in-flight words, and no tail is emitted.

## Timing
- FIFO read data is registered (1-cycle read latency), and the egress port is registered.
- Tail written at cycle T: the FSM sees `pkt_cnt` at T+1, grants at T+1, and the header appears on `out_data` at T+3. This is the minimum cut-through-free latency.
- An N-word packet occupies `out_data_wr` for exactly N consecutive cycles.
- There is at least 1 idle egress cycle between packets.
- `out_data_alf` is sampled only in IDLE. Asserting it during SEND never truncates or stalls the packet.
- Simultaneous head arrival on the same cycle a FIFO frees space: admission uses the occupancy registered at the start of that cycle.

## Configuration
- `PKT_ARB_PTP_PRIO_EN`:
  - Defined: strict priority. Input 1 (PTP) wins whenever it requests in IDLE; input 0 is granted only when `pkt_cnt1`=0. Granting is still non-preemptive at packet granularity.
  - Undefined: round-robin as above.

## Structure
- Shared package `pkt_arb_pkg`:
  - Header codes `HDR_HEAD`=2'b01, `HDR_BODY`=2'b11, `HDR_TAIL`=2'b10.
  - `PKT_W`=134.
  - FSM state enum {IDLE, SEND}.
- Sub-module `pkt_adm_fifo`, instantiated twice. It contains the admission/discard logic, the 135-bit synchronous FIFO, `pkt_cnt`, alf and the drop counter. It exposes `rd_en`, `rd_data`, `pkt_avail`.
- The top level holds the arbiter FSM, the `last` register and the egress registers.

## Test plan
- **Single packet.** 4-word packet on in0, valid=1, tail at cycle 10 → `out_data` carries the same 4 words on cycles 13–16; `out_data_valid_wr`=`out_data_valid`=1 at 16 only.
- **Round-robin.** Complete 3-word packets pending on both inputs, repeatedly, with the macro undefined → egress order in0, in1, in0, in1; 1 idle cycle between packets.
- **Strict priority.** Same stimulus with `PKT_ARB_PTP_PRIO_EN` defined and three in1 packets queued → all three in1 packets are emitted before any in0 packet.
- **Admission drop.** Fill in0 to 129 words with out_data_alf held at 1, so free space = 127 and alf=1; send a 5-word head → packet discarded, `drop_cnt0`=1. Release backpressure → only the earlier packets are emitted.
- **Backpressure.** `out_data_alf`=1 raised mid-SEND of a 10-word packet → all 10 words are emitted contiguously; the next pending packet waits until alf=0.
- **Reset mid-packet.** `rst_n`=0 for 1 cycle during word 2 of 6 → all outputs 0 the next cycle; no tail emitted; FIFOs empty; `pkt_cnt`=0.
